// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl
// Sequencer and owner of the HI/LO register pair for the EXE stage.
// Runs one MULT/MULTU/DIV/DIVU/MTHI/MTLO command at a time. Multiplies use
// radix-2 shift-add and divides use restoring division, one step per cycle
// for WIDTH cycles. Signed operations are done on magnitudes and the signs
// are fixed up in a final FIX cycle.
//
// Ports:
//   clk    - clock
//   reset  - asynchronous, active-high reset
//   start  - command valid, sampled only while idle
//   op     - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others ignored
//   src1   - multiplicand / dividend / MTHI-MTLO data
//   src2   - multiplier / divisor
//   cancel - pipeline flush; aborts the command without touching HI/LO
//   busy   - high whenever a command is in flight (any state but IDLE)
//   over   - one-cycle pulse: command finished and HI/LO updated
//   hi, lo - HI and LO registers
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             over,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t             state, state_n;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   src1_q, src2_q;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      counter;
  logic               sign_q, sign_r;

  logic               in_valid, in_mt, accept;
  logic               q_is_div, q_is_signed;
  logic               s1_neg, s2_neg;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] product_n;
  logic [WIDTH-1:0]   quot_n, rem_n;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Command decode: incoming op for acceptance, latched op for the datapath.
  assign in_valid    = (op <= OP_MTLO);
  assign in_mt       = (op == OP_MTHI) || (op == OP_MTLO);
  assign accept      = start && !cancel && in_valid;
  assign q_is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign q_is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  // Magnitudes for signed ops; 0x80..0 maps to itself, which is the right
  // unsigned magnitude.
  assign s1_neg = q_is_signed && src1_q[WIDTH-1];
  assign s2_neg = q_is_signed && src2_q[WIDTH-1];
  assign abs1   = s1_neg ? -src1_q : src1_q;
  assign abs2   = s2_neg ? -src2_q : src2_q;

  // Shift-add step: acc holds {partial product, remaining multiplier bits}.
  // The carry out of the add becomes the new top bit after the shift.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: acc holds {partial remainder, dividend/quotient bits}.
  // A borrow shows up in the extra top bit of the trial subtraction.
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
  assign div_step  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix-up; sign flags are cleared for unsigned ops so these pass through.
  assign product_n = sign_q ? -acc : acc;
  assign quot_n    = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_n     = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign fix_hi    = q_is_div ? rem_n  : product_n[2*WIDTH-1:WIDTH];
  assign fix_lo    = q_is_div ? quot_n : product_n[WIDTH-1:0];

  assign busy = (state != IDLE);
  assign over = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic. cancel overrides everything once a command is in
  // flight, and also drops a command offered in the same cycle while idle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = in_mt ? DONE : PREP;
      PREP: state_n = (q_is_div && (src2_q == '0)) ? DONE : CALC;
      CALC: if (counter == CW'(WIDTH - 1)) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (cancel && (state != IDLE)) state_n = IDLE;
  end

  // Datapath. Only the HI/LO writes are gated by cancel; scratch registers
  // may update freely because an aborted command never reaches FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      opnd    <= '0;
      acc     <= '0;
      counter <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= op;
            src1_q <= src1;
            src2_q <= src2;
            if (op == OP_MTHI) hi <= src1;
            if (op == OP_MTLO) lo <= src1;
          end
        end
        PREP: begin
          sign_q  <= s1_neg ^ s2_neg;
          sign_r  <= s1_neg;
          counter <= '0;
          acc     <= {{WIDTH{1'b0}}, (q_is_div ? abs1 : abs2)};
          opnd    <= q_is_div ? abs2 : abs1;
        end
        CALC: begin
          counter <= counter + 1'b1;
          acc     <= q_is_div ? div_step : mul_step;
        end
        FIX: begin
          if (!cancel) begin
            hi <= fix_hi;
            lo <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl (WIDTH=32). Expected HI/LO values
// come from plain 64-bit arithmetic on the operands.
module tb_hilo_muldiv_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src1, src2;
  logic         cancel;
  logic         busy, over;
  logic [W-1:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src1(src1), .src2(src2),
    .cancel(cancel), .busy(busy), .over(over), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: architectural result of a command on the HI/LO pair.
  function automatic void model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b != 0) begin
              q = sa / sb; r = sa % sb;
              p = 64'(q); m_lo = p[31:0];
              p = 64'(r); m_hi = p[31:0];
            end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] b);
    if (o == 3'd4 || o == 3'd5) return 1;
    if ((o == 3'd2 || o == 3'd3) && b == 0) return 2;
    return 35;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one command from a negedge with the DUT idle; returns the number of
  // edges until over is seen (-1 on timeout), whether busy stayed high, and
  // over/busy one cycle after the pulse.
  task automatic run_cmd(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output bit busy_ok,
                         output logic over_after, output logic busy_after);
    op = o; src1 = a; src2 = b; start = 1'b1;
    cycles = -1; busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (over) begin cycles = i; break; end
    end
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    over_after = over;
    busy_after = busy;
  endtask

  task automatic test_reset();
    int cyc; bit bok; logic oa, ba;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || over !== 1'b0 || hi !== 0 || lo !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got busy=%b over=%b hi=%h lo=%h, wanted all zero", busy, over, hi, lo);
    end
    reset = 1'b0;
    @(negedge clk);
    // Preload HI/LO so the mid-CALC reset has something to clear.
    run_cmd(3'd4, 32'hDEAD_0000, 0, cyc, bok, oa, ba);
    run_cmd(3'd5, 32'h0000_BEEF, 0, cyc, bok, oa, ba);
    op = 3'd1; src1 = $urandom; src2 = $urandom; start = 1'b1;
    repeat (12) begin @(posedge clk); @(negedge clk); end
    reset = 1'b1; start = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || over !== 1'b0 || hi !== 0 || lo !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_calc: got busy=%b over=%b hi=%h lo=%h, wanted all zero", busy, over, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    run_cmd(3'd1, 32'd3, 32'd5, cyc, bok, oa, ba);
    model_apply(3'd1, 32'd3, 32'd5);
    tests_run++;
    if (cyc != 35 || hi !== 32'h0 || lo !== 32'h0000_000F) begin
      tests_failed++;
      $display("[TB] FAIL multu_after_reset: got cycles=%0d hi=%h lo=%h, wanted 35 00000000 0000000f", cyc, hi, lo);
    end
  endtask

  task automatic test_mul_div_directed();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100};
    logic [31:0] bs  [4] = '{32'h2, 32'h2, 32'h2, 32'd7};
    logic [31:0] ehi [4] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h2};
    logic [31:0] elo [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hE};
    int cyc; bit bok; logic oa, ba;
    for (int i = 0; i < 4; i++) begin
      run_cmd(ops[i], as[i], bs[i], cyc, bok, oa, ba);
      model_apply(ops[i], as[i], bs[i]);
      tests_run++;
      if (cyc != 35 || !bok || hi !== ehi[i] || lo !== elo[i] || oa !== 1'b0 || ba !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL directed_%0d: got cycles=%0d busy_ok=%0d hi=%h lo=%h over_after=%b busy_after=%b, wanted 35 1 %h %h 0 0",
                 i, cyc, bok, hi, lo, oa, ba, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_div_zero_and_mt();
    int cyc; bit bok; logic oa, ba;
    run_cmd(3'd4, 32'h0000_1234, 0, cyc, bok, oa, ba);
    model_apply(3'd4, 32'h0000_1234, 0);
    run_cmd(3'd5, 32'h0000_5678, 0, cyc, bok, oa, ba);
    model_apply(3'd5, 32'h0000_5678, 0);
    run_cmd(3'd2, $urandom, 32'h0, cyc, bok, oa, ba);
    tests_run++;
    if (cyc != 2 || hi !== 32'h1234 || lo !== 32'h5678 || oa !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL div_by_zero: got cycles=%0d hi=%h lo=%h over_after=%b, wanted 2 00001234 00005678 0", cyc, hi, lo, oa);
    end
    run_cmd(3'd4, 32'hAAAA_0000, 0, cyc, bok, oa, ba);
    model_apply(3'd4, 32'hAAAA_0000, 0);
    tests_run++;
    if (cyc != 1 || hi !== 32'hAAAA_0000 || lo !== 32'h5678 || oa !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mthi: got cycles=%0d hi=%h lo=%h over_after=%b, wanted 1 aaaa0000 00005678 0", cyc, hi, lo, oa);
    end
  endtask

  task automatic test_cancel();
    int overs;
    int first_over;
    logic [31:0] a, b;
    // Cancel while the counter is at 10.
    op = 3'd0; src1 = $urandom | 32'h1; src2 = $urandom | 32'h1; start = 1'b1;
    repeat (12) begin @(posedge clk); @(negedge clk); end
    cancel = 1'b1; start = 1'b0;
    @(posedge clk); @(negedge clk);
    cancel = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || over !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL cancel_to_idle: got busy=%b over=%b, wanted 0 0", busy, over);
    end
    overs = 0;
    repeat (40) begin @(posedge clk); @(negedge clk); if (over) overs++; end
    tests_run++;
    if (overs != 0 || hi !== m_hi || lo !== m_lo) begin
      tests_failed++;
      $display("[TB] FAIL cancel_no_write: got overs=%0d hi=%h lo=%h, wanted 0 %h %h", overs, hi, lo, m_hi, m_lo);
    end
    // start together with cancel while idle is dropped.
    op = 3'd4; src1 = ~m_hi; start = 1'b1; cancel = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== m_hi) begin
      tests_failed++;
      $display("[TB] FAIL cancel_with_start: got busy=%b hi=%h, wanted 0 %h", busy, hi, m_hi);
    end
    // Operands changed mid-command must not matter; exactly one pulse.
    a = $urandom; b = $urandom;
    op = 3'd1; src1 = a; src2 = b; start = 1'b1;
    overs = 0; first_over = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 5) begin op = 3'd3; src1 = ~a; src2 = 32'd3; end
      if (over) begin
        overs++;
        if (first_over < 0) first_over = i;
        start = 1'b0;
      end
    end
    model_apply(3'd1, a, b);
    tests_run++;
    if (overs != 1 || first_over != 35 || hi !== m_hi || lo !== m_lo) begin
      tests_failed++;
      $display("[TB] FAIL start_while_busy: got overs=%0d at=%0d hi=%h lo=%h, wanted 1 35 %h %h",
               overs, first_over, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic idle_busy;
    op = 3'd1; src1 = 32'd2; src2 = 32'd2; start = 1'b1;
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); @(negedge clk);
      if (over) begin cyc = i; break; end
    end
    tests_run++;
    if (cyc != 35 || lo !== 32'd4 || hi !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got cycles=%0d hi=%h lo=%h, wanted 35 00000000 00000004", cyc, hi, lo);
    end
    op = 3'd3; src1 = 32'd9; src2 = 32'd3;
    cyc = -1; idle_busy = 1'bx;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 1) idle_busy = busy;
      if (over) begin cyc = i; break; end
    end
    start = 1'b0;
    tests_run++;
    if (cyc != 36 || idle_busy !== 1'b0 || lo !== 32'd3 || hi !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got cycles=%0d idle_busy=%b hi=%h lo=%h, wanted 36 0 00000000 00000003",
               cyc, idle_busy, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd3;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, overs; bit bok; logic oa, ba;
    logic [2:0] o; logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      if (o > 3'd5) begin
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        overs = 0;
        repeat (3) begin if (over || busy) overs++; @(posedge clk); @(negedge clk); end
        tests_run++;
        if (overs != 0 || hi !== m_hi || lo !== m_lo) begin
          tests_failed++;
          $display("[TB] FAIL rand_invalid_%0d: got activity=%0d hi=%h lo=%h, wanted 0 %h %h", n, overs, hi, lo, m_hi, m_lo);
        end
      end else begin
        run_cmd(o, a, b, cyc, bok, oa, ba);
        model_apply(o, a, b);
        tests_run++;
        if (cyc != exp_latency(o, b) || !bok || hi !== m_hi || lo !== m_lo || oa !== 1'b0 || ba !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL rand_%0d op=%0d a=%h b=%h: got cycles=%0d busy_ok=%0d hi=%h lo=%h over_after=%b, wanted %0d 1 %h %h 0",
                   n, o, a, b, cyc, bok, hi, lo, oa, exp_latency(o, b), m_hi, m_lo);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int cyc; bit bok; logic oa, ba;
    run_cmd(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, bok, oa, ba);
    model_apply(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    tests_run++;
    if (cyc != 35 || lo !== 32'h8000_0000 || hi !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL div_overflow: got cycles=%0d hi=%h lo=%h, wanted 35 00000000 80000000", cyc, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mul_div_directed();
    test_div_zero_and_mt();
    test_overflow();
    test_cancel();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
